// File: rtl/jpeg_idct_transpose_rd.sv
// Read-side controller for the 64x16 IDCT transpose RAM: streams one 8x8 block
// out in column-major (or linear) order through a 2-entry skid FIFO.
module jpeg_idct_transpose_rd #(
    parameter int DATA_W    = 16,
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [5:0]        ram_addr_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              outport_valid_o,
    output logic [DATA_W-1:0] outport_data_o,
    output logic [5:0]        outport_idx_o,
    output logic              outport_last_o,
    input  logic              outport_accept_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q;
    logic [5:0]        issueIdx_q;
    logic [5:0]        lastAddr_q;
    logic [5:0]        flightIdx_q;
    logic              inFlight_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] fifoData_q [2];
    logic [5:0]        fifoIdx_q  [2];
    logic              wrPtr_q;
    logic              rdPtr_q;
    logic [1:0]        fifoCount_q;
    logic [1:0]        fifoCount_d;

    logic              push;
    logic              pop;
    logic              issue;
    logic              lastPop;
    logic [5:0]        issueAddr;

    // A read is only issued when the word it returns is guaranteed a FIFO slot,
    // counting the word already returning from the RAM and this cycle's pop.
    always_comb begin
        push        = inFlight_q;
        pop         = (fifoCount_q != 2'd0) && outport_accept_i;
        issue       = (state_q == READ) &&
                      (({1'b0, fifoCount_q} + {2'b00, inFlight_q}) < (3'd2 + {2'b00, pop}));
        lastPop     = pop && (fifoIdx_q[rdPtr_q] == 6'd63);
        issueAddr   = TRANSPOSE ? {issueIdx_q[2:0], issueIdx_q[5:3]} : issueIdx_q;
        fifoCount_d = fifoCount_q + {1'b0, push} - {1'b0, pop};
    end

    assign ram_addr_o      = issue ? issueAddr : lastAddr_q;
    assign outport_valid_o = (fifoCount_q != 2'd0);
    assign outport_data_o  = fifoData_q[rdPtr_q];
    assign outport_idx_o   = fifoIdx_q[rdPtr_q];
    assign outport_last_o  = outport_valid_o && (fifoIdx_q[rdPtr_q] == 6'd63);
    assign busy_o          = busy_q;
    assign done_o          = done_q;

    // DRAIN lingers through the done cycle so a start coinciding with done is ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            issueIdx_q    <= 6'd0;
            lastAddr_q    <= 6'd0;
            flightIdx_q   <= 6'd0;
            inFlight_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fifoData_q[0] <= '0;
            fifoData_q[1] <= '0;
            fifoIdx_q[0]  <= 6'd0;
            fifoIdx_q[1]  <= 6'd0;
            wrPtr_q       <= 1'b0;
            rdPtr_q       <= 1'b0;
            fifoCount_q   <= 2'd0;
        end else begin
            inFlight_q  <= issue;
            done_q      <= 1'b0;
            fifoCount_q <= fifoCount_d;
            if (issue) begin
                flightIdx_q <= issueIdx_q;
                lastAddr_q  <= issueAddr;
                issueIdx_q  <= issueIdx_q + 6'd1;
            end
            if (push) begin
                fifoData_q[wrPtr_q] <= ram_data_i;
                fifoIdx_q[wrPtr_q]  <= flightIdx_q;
                wrPtr_q             <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= READ;
                        busy_q     <= 1'b1;
                        issueIdx_q <= 6'd0;
                    end
                end
                READ: begin
                    if (issue && (issueIdx_q == 6'd63)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done_q) begin
                        state_q <= IDLE;
                    end else if (lastPop) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_idct_transpose_rd.sv
// Directed bench for jpeg_idct_transpose_rd: a transposing and a linear instance
// share stimulus and are each checked against a preloaded RAM (ram[a] = 3*a).
module tb_jpeg_idct_transpose_rd;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic        accept = 1'b1;

    logic [5:0]  ramAddrT, ramAddrL, idxT, idxL;
    logic [15:0] ramDataT, ramDataL, dataT, dataL;
    logic        validT, validL, lastT, lastL, busyT, busyL, doneT, doneL;

    logic [15:0] ram [64];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    jpeg_idct_transpose_rd #(.DATA_W(16), .TRANSPOSE(1'b1)) dutT (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .ram_addr_o(ramAddrT), .ram_data_i(ramDataT),
        .outport_valid_o(validT), .outport_data_o(dataT), .outport_idx_o(idxT),
        .outport_last_o(lastT), .outport_accept_i(accept),
        .busy_o(busyT), .done_o(doneT)
    );

    jpeg_idct_transpose_rd #(.DATA_W(16), .TRANSPOSE(1'b0)) dutL (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .ram_addr_o(ramAddrL), .ram_data_i(ramDataL),
        .outport_valid_o(validL), .outport_data_o(dataL), .outport_idx_o(idxL),
        .outport_last_o(lastL), .outport_accept_i(accept),
        .busy_o(busyL), .done_o(doneL)
    );

    // Registered-read RAM models, one per instance.
    always @(posedge clk) begin
        ramDataT <= ram[ramAddrT];
        ramDataL <= ram[ramAddrL];
    end

    function automatic logic [15:0] expT(input int idx);
        return 16'((((idx % 8) * 8) + (idx / 8)) * 3);
    endfunction

    function automatic logic [15:0] expL(input int idx);
        return 16'(idx * 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_validT"}, 32'(validT), 32'd0);
        check({tag, "_lastT"},  32'(lastT),  32'd0);
        check({tag, "_busyT"},  32'(busyT),  32'd0);
        check({tag, "_doneT"},  32'(doneT),  32'd0);
        check({tag, "_addrT"},  32'(ramAddrT), 32'd0);
        check({tag, "_idxT"},   32'(idxT),   32'd0);
        check({tag, "_dataT"},  32'(dataT),  32'd0);
        check({tag, "_validL"}, 32'(validL), 32'd0);
        check({tag, "_busyL"},  32'(busyL),  32'd0);
        check({tag, "_doneL"},  32'(doneL),  32'd0);
        check({tag, "_addrL"},  32'(ramAddrL), 32'd0);
    endtask

    // Called at a falling edge; start is sampled at the next rising edge (edge N).
    // accMode 0: accept held high; 1: accept 1,0,0,1 with a 20-cycle stall at idx 32.
    task automatic runBlock(input int accMode, input bit pulseRestart, input int abortAt, input bit b2b);
        int         cyc;
        int         expIdx;
        int         stallCnt;
        int         doneSeen;
        int         lastAccCyc;
        bit         stallDone;
        logic [3:0] pat;
        pat        = 4'b1001;
        expIdx     = 0;
        stallCnt   = 0;
        stallDone  = 1'b0;
        doneSeen   = 0;
        lastAccCyc = -10;
        accept     = (accMode == 0) ? 1'b1 : pat[0];
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busyAfterStart", 32'(busyT), 32'd1);
        check("firstAddrT", 32'(ramAddrT), 32'd0);
        check("firstAddrL", 32'(ramAddrL), 32'd0);
        check("noValidAtN1", 32'(validT), 32'd0);
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                check("cycleBudget", 32'(cyc), 32'd400);
                break;
            end
            if (accMode == 0 && abortAt < 0) begin
                check("validWindow", 32'(validT), 32'(cyc >= 3 && cyc <= 66));
                check("doneWindow", 32'(doneT), 32'(cyc == 67));
            end
            check("validMatchL", 32'(validL), 32'(validT));
            if (validT) begin
                check("idxT",  32'(idxT),  32'(expIdx));
                check("dataT", 32'(dataT), 32'(expT(expIdx)));
                check("lastT", 32'(lastT), 32'(expIdx == 63));
            end
            if (validL) begin
                check("idxL",  32'(idxL),  32'(expIdx));
                check("dataL", 32'(dataL), 32'(expL(expIdx)));
                check("lastL", 32'(lastL), 32'(expIdx == 63));
            end
            check("busyT", 32'(busyT), 32'(expIdx < 64));
            check("busyL", 32'(busyL), 32'(expIdx < 64));
            check("doneT", 32'(doneT), 32'(lastAccCyc == cyc - 1));
            check("doneL", 32'(doneL), 32'(lastAccCyc == cyc - 1));
            check("fifoLevelT", 32'(dutT.fifoCount_q <= 2'd2), 32'd1);
            if (doneT) doneSeen++;
            if (abortAt >= 0 && validT && idxT == 6'(abortAt)) begin
                #2 rst = 1'b1;
                #1;
                check("abortValidT", 32'(validT), 32'd0);
                check("abortBusyT",  32'(busyT),  32'd0);
                check("abortDoneT",  32'(doneT),  32'd0);
                check("abortAddrT",  32'(ramAddrT), 32'd0);
                check("abortValidL", 32'(validL), 32'd0);
                check("abortBusyL",  32'(busyL),  32'd0);
                break;
            end
            if (lastAccCyc == cyc - 1) begin
                start = b2b;
                break;
            end
            if (accMode == 1) begin
                if (!stallDone && expIdx == 32) begin
                    stallCnt  = 20;
                    stallDone = 1'b1;
                end
                accept = (stallCnt > 0) ? 1'b0 : pat[cyc % 4];
                if (stallCnt > 0) stallCnt--;
            end
            if (validT && accept) begin
                if (expIdx == 63) lastAccCyc = cyc;
                expIdx++;
            end
            start = pulseRestart && validT && (idxT == 6'd10 || idxT == 6'd40);
        end
        if (abortAt < 0) begin
            check("singleDone", 32'(doneSeen), 32'd1);
            check("allWords",   32'(expIdx),   32'd64);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 16'(i * 3);
        @(negedge clk);
        checkReset("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic readout, then a start in the done cycle (ignored) and one cycle later.
        runBlock(0, 1'b0, -1, 1'b1);
        @(negedge clk);
        check("b2bIgnoredBusy",  32'(busyT),  32'd0);
        check("b2bIgnoredValid", 32'(validT), 32'd0);
        runBlock(0, 1'b1, -1, 1'b0);

        @(negedge clk);
        runBlock(1, 1'b0, -1, 1'b0);

        @(negedge clk);
        runBlock(0, 1'b0, 30, 1'b0);
        @(negedge clk);
        checkReset("midReset");
        rst = 1'b0;
        @(negedge clk);
        runBlock(0, 1'b0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
